// File: rtl/lod_normalizer_pipe_if.sv
// Handshake and payload bundle for the leading-bit detector/normaliser.
// The master side produces items and consumes results; the slave side is the pipeline.
interface lod_normalizer_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int PW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic             out_found;
  logic [PW-1:0]    out_position;
  logic [PW-1:0]    out_shift;
  logic [WIDTH-1:0] out_normalized;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_value, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_found, out_position, out_shift, out_normalized, out_tag
  );

  modport slave (
    input  in_valid, in_value, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_found, out_position, out_shift, out_normalized, out_tag
  );
endinterface

// File: rtl/lod_normalizer_pipe.sv
// Leading-one / trailing-one / leading-sign detector with normalising shift, PIPE_STAGES cycles latency.
// Valid/ready skid-free pipeline: a stage loads when any stage from it to the output is empty or the output retires.
module lod_normalizer_pipe #(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input logic                clk,
  input logic                rst,
  lod_normalizer_pipe_if.slave bus
);
  localparam int PW = $clog2(WIDTH);

  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("lod_normalizer_pipe: PIPE_STAGES must be 1..4");
  end
  if (WIDTH < 4) begin : g_bad_width
    $error("lod_normalizer_pipe: WIDTH must be >= 4");
  end

  typedef struct packed {
    logic             found;
    logic [PW-1:0]    pos;
    logic [PW-1:0]    shift;
    logic [WIDTH-1:0] norm;
    logic [TAG_W-1:0] tag;
  } res_t;

  // Full detect-and-shift result for one item; mode 11 falls through to the leading-one path.
  function automatic res_t detect(input logic [WIDTH-1:0] v, input logic [1:0] m,
                                  input logic [TAG_W-1:0] tg);
    res_t             r;
    logic [WIDTH-1:0] t;
    r      = '0;
    r.tag  = tg;
    r.norm = v;
    t      = v;
    if (m == 2'b10) begin
      t            = v ^ {WIDTH{v[WIDTH-1]}};
      t[WIDTH-1]   = 1'b0;
    end
    r.found = |t;
    if (m == 2'b01) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (t[i]) r.pos = PW'(i);
      end
      r.shift = r.pos;
      if (r.found) r.norm = v >> r.shift;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (t[i]) r.pos = PW'(i);
      end
      if (r.found) begin
        r.shift = (m == 2'b10) ? (PW'(WIDTH - 2) - r.pos) : (PW'(WIDTH - 1) - r.pos);
        r.norm  = v << r.shift;
      end
    end
    return r;
  endfunction

  res_t                   in_res;
  res_t                   st_dat  [PIPE_STAGES];
  res_t                   prv_dat [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] st_vld;
  logic [PIPE_STAGES-1:0] prv_vld;
  logic [PIPE_STAGES-1:0] can_load;

  assign in_res = detect(bus.in_value, bus.in_mode, bus.in_tag);

  always_comb begin
    prv_vld    = '0;
    prv_vld[0] = bus.in_valid;
    prv_dat[0] = in_res;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      prv_vld[k] = st_vld[k-1];
      prv_dat[k] = st_dat[k-1];
    end
  end

  // Written in closed form (any hole downstream, or a retire) to keep the ready chain acyclic.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    can_load = '0;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      all_full = 1'b1;
      for (int j = k; j < PIPE_STAGES; j++) begin
        all_full = all_full & st_vld[j];
      end
      can_load[k] = bus.out_ready | ~all_full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_vld <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        st_dat[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (can_load[k]) begin
          st_vld[k] <= prv_vld[k];
          if (prv_vld[k]) st_dat[k] <= prv_dat[k];
        end
      end
    end
  end

  assign bus.in_ready       = can_load[0];
  assign bus.out_valid      = st_vld[PIPE_STAGES-1];
  assign bus.out_found      = st_dat[PIPE_STAGES-1].found;
  assign bus.out_position   = st_dat[PIPE_STAGES-1].pos;
  assign bus.out_shift      = st_dat[PIPE_STAGES-1].shift;
  assign bus.out_normalized = st_dat[PIPE_STAGES-1].norm;
  assign bus.out_tag        = st_dat[PIPE_STAGES-1].tag;
endmodule

// File: tb/tb_lod_normalizer_pipe.sv
// Randomised and directed bench for lod_normalizer_pipe against an arithmetic reference model.
module tb_lod_normalizer_pipe;
  localparam int W  = 8;
  localparam int NS = 2;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lod_normalizer_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();
  lod_normalizer_pipe #(.WIDTH(W), .PIPE_STAGES(NS), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic found;
    int   pos;
    int   shift;
    int   norm;
    int   tag;
    int   acc;
  } exp_t;

  exp_t q[$];
  exp_t nil;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cycle  = 0;
  logic lat_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference: scan the value arithmetically, no bit-vector tricks.
  function automatic exp_t model(input int v, input int m, input int tg);
    exp_t e;
    int   s;
    e.found = 1'b0; e.pos = 0; e.shift = 0; e.norm = v; e.tag = tg; e.acc = 0;
    if (m == 1) begin
      if (v != 0) begin
        e.found = 1'b1;
        while (((v >> e.pos) & 1) == 0) e.pos++;
        e.shift = e.pos;
        e.norm  = v >> e.shift;
      end
    end else begin
      if (m == 2) s = (((v >> (W - 1)) & 1) != 0) ? (~v) & ((1 << (W - 1)) - 1)
                                                 : v & ((1 << (W - 1)) - 1);
      else        s = v;
      if (s != 0) begin
        e.found = 1'b1;
        while ((s >> (e.pos + 1)) != 0) e.pos++;
        e.shift = ((m == 2) ? W - 2 : W - 1) - e.pos;
        e.norm  = (v << e.shift) & ((1 << W) - 1);
      end
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic f, input int p, input int s, input int n, input int tg);
    exp_t e;
    e.found = f; e.pos = p; e.shift = s; e.norm = n; e.tag = tg; e.acc = 0;
    return e;
  endfunction

  // One clock: drive at negedge, sample settled handshakes, then let the posedge happen.
  task automatic cyc(input logic r, input logic iv, input int val, input int md, input int tg,
                     input logic ordy, input exp_t ex, output logic acc);
    exp_t e;
    @(negedge clk);
    rst           = r;
    bus.in_valid  = iv;
    bus.in_value  = W'(val);
    bus.in_mode   = 2'(md);
    bus.in_tag    = TW'(tg);
    bus.out_ready = ordy;
    #1;
    acc = 1'b0;
    if (!r) begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'(bus.out_valid), 32'(0));
        end else begin
          e = q[0];
          chk("found", 32'(bus.out_found),      32'(e.found));
          chk("pos",   32'(bus.out_position),   32'(e.pos));
          chk("shift", 32'(bus.out_shift),      32'(e.shift));
          chk("norm",  32'(bus.out_normalized), 32'(e.norm));
          chk("tag",   32'(bus.out_tag),        32'(e.tag));
          if (ordy) begin
            if (lat_on) chk("latency", 32'(cycle - e.acc), 32'(NS));
            void'(q.pop_front());
          end
        end
      end
      if (iv && bus.in_ready) begin
        acc   = 1'b1;
        e     = ex;
        e.acc = cycle;
        q.push_back(e);
      end
    end
    cycle++;
  endtask

  task automatic push_item(input int val, input int md, input int tg, input exp_t ex,
                           input int rdy_pct);
    logic acc;
    logic rdy;
    int   n;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      rdy = (int'($urandom_range(0, 99)) < rdy_pct);
      cyc(1'b0, 1'b1, val, md, tg, rdy, ex, acc);
      n++;
    end
    chk("accept", 32'(acc), 32'(1));
  endtask

  task automatic drain();
    logic a;
    int   n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      cyc(1'b0, 1'b0, 0, 0, 0, 1'b1, nil, a);
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   d_val [7] = '{8'h10, 8'h28, 8'h01, 8'hF3, 8'h00, 8'hFF, 8'h00};
    int   d_md  [7] = '{0, 1, 3, 2, 2, 2, 0};
    int   d_fnd [7] = '{1, 1, 1, 1, 0, 0, 0};
    int   d_pos [7] = '{4, 3, 0, 3, 0, 0, 0};
    int   d_sh  [7] = '{3, 3, 7, 3, 0, 0, 0};
    int   d_nrm [7] = '{8'h80, 8'h05, 8'h80, 8'h98, 8'h00, 8'hFF, 8'h00};
    int   v, m;

    bus.in_valid = 1'b0; bus.in_value = '0; bus.in_mode = '0; bus.in_tag = '0;
    bus.out_ready = 1'b0;
    nil = model(0, 0, 0);

    repeat (2) cyc(1'b1, 1'b0, 0, 0, 0, 1'b1, nil, acc);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1, nil, acc);
    chk("rst_out_valid", 32'(bus.out_valid),      32'(0));
    chk("rst_in_ready",  32'(bus.in_ready),       32'(1));
    chk("rst_found",     32'(bus.out_found),      32'(0));
    chk("rst_pos",       32'(bus.out_position),   32'(0));
    chk("rst_shift",     32'(bus.out_shift),      32'(0));
    chk("rst_norm",      32'(bus.out_normalized), 32'(0));
    chk("rst_tag",       32'(bus.out_tag),        32'(0));

    // Directed examples, back to back at full rate.
    lat_on = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push_item(d_val[i], d_md[i], i + 3,
                mk(d_fnd[i][0], d_pos[i], d_sh[i], d_nrm[i], i + 3), 100);
    end
    drain();

    // Full-rate stream 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      m = int'($urandom_range(0, 3));
      push_item(i, m, i % 16, model(i, m, i % 16), 100);
    end
    drain();
    lat_on = 1'b0;

    // Same stream with 50% downstream backpressure.
    for (int i = 1; i <= 16; i++) begin
      m = int'($urandom_range(0, 3));
      push_item(i, m, i % 16, model(i, m, i % 16), 50);
    end
    drain();

    // Stall: two items fill the stages, the third must be refused while outputs hold.
    cyc(1'b0, 1'b1, 8'h40, 0, 5, 1'b0, model(8'h40, 0, 5), acc);
    chk("stall_acc0", 32'(acc), 32'(1));
    cyc(1'b0, 1'b1, 8'h0C, 1, 6, 1'b0, model(8'h0C, 1, 6), acc);
    chk("stall_acc1", 32'(acc), 32'(1));
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 8'h77, 2, 7, 1'b0, model(8'h77, 2, 7), acc);
      chk("stall_in_ready", 32'(acc), 32'(0));
    end
    drain();

    // Reset with two items in flight.
    cyc(1'b0, 1'b1, 8'h21, 0, 1, 1'b0, model(8'h21, 0, 1), acc);
    cyc(1'b0, 1'b1, 8'h30, 1, 2, 1'b0, model(8'h30, 1, 2), acc);
    cyc(1'b1, 1'b1, 8'h55, 0, 3, 1'b1, nil, acc);
    q.delete();
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1, nil, acc);
    chk("flush_out_valid", 32'(bus.out_valid), 32'(0));
    chk("flush_in_ready",  32'(bus.in_ready),  32'(1));
    lat_on = 1'b1;
    push_item(8'h06, 1, 9, model(8'h06, 1, 9), 100);
    drain();

    // Exhaustive over all values and modes at full rate.
    for (int mm = 0; mm < 4; mm++) begin
      for (int vv = 0; vv < 256; vv++) begin
        push_item(vv, mm, vv % 16, model(vv, mm, vv % 16), 100);
      end
    end
    drain();
    lat_on = 1'b0;

    // Random values, modes and backpressure.
    for (int i = 0; i < 400; i++) begin
      v = int'($urandom_range(0, 255));
      m = int'($urandom_range(0, 3));
      push_item(v, m, i % 16, model(v, m, i % 16), 70);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
